// File: rtl/systolic_pe_os.sv
// Output-stationary systolic PE: forwards activations right and weights
// down, runs a saturating MAC over k_len valid pairs, then drains results.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     global advance (stall when low)
//   start, k_len, signed_mode  tile start, reduction length, operand mode
//   data_in/_valid_in          activation from the left
//   data_out/_valid_out        registered activation to the right
//   weight_in/_valid_in        weight from above
//   weight_out/_valid_out      registered weight downward
//   result_in/_valid_in        upstream result, result_ready_out back
//   result_out/_valid_out      result to PE below, result_ready_in back
//   busy, sat_flag             not idle / saturation seen this tile
module systolic_pe_os #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter int K_MAX        = 256,
    parameter int CHAIN_POS    = 0,
    localparam int KW          = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    signed_mode,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    data_valid_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid_out,
    input  logic [WEIGHT_WIDTH-1:0] weight_in,
    input  logic                    weight_valid_in,
    output logic [WEIGHT_WIDTH-1:0] weight_out,
    output logic                    weight_valid_out,
    input  logic [ACCUM_WIDTH-1:0]  result_in,
    input  logic                    result_valid_in,
    output logic                    result_ready_out,
    output logic [ACCUM_WIDTH-1:0]  result_out,
    output logic                    result_valid_out,
    input  logic                    result_ready_in,
    output logic                    busy,
    output logic                    sat_flag
);

    localparam int A  = ACCUM_WIDTH;
    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
    // Two guard bits above the wider of product/accumulator so the
    // pre-clamp sum can never wrap.
    localparam int SW = ((A > PW) ? A : PW) + 2;
    localparam int CW = (CHAIN_POS > 0) ? $clog2(CHAIN_POS + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2,
        S_PASS  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_dv;
    logic [WEIGHT_WIDTH-1:0] r_wt;
    logic                    r_wv;
    logic [KW-1:0]           r_klen;
    logic [KW-1:0]           r_kcnt;
    logic                    r_sgn;
    logic [A-1:0]            r_acc;
    logic                    r_sat;
    logic [A-1:0]            r_res;
    logic                    r_res_valid;
    logic [CW-1:0]           r_fcnt;

    logic [PW-1:0]           w_dx;
    logic [PW-1:0]           w_wx;
    logic [PW-1:0]           w_prod;
    logic [SW-1:0]           w_prod_x;
    logic [SW-1:0]           w_acc_x;
    logic [SW-1:0]           w_sum;
    logic                    w_ovf;
    logic [A-1:0]            w_clamp;
    logic [A-1:0]            w_next;
    logic                    w_fire;
    logic [KW-1:0]           w_kcnt_nx;
    logic                    w_ready;
    logic                    w_load;
    logic                    w_drain;

    // Operands extended to product width; the low PW bits of the product
    // are then exact for both signed and unsigned interpretation.
    assign w_dx = r_sgn ? {{WEIGHT_WIDTH{data_in[DATA_WIDTH-1]}}, data_in}
                        : {{WEIGHT_WIDTH{1'b0}}, data_in};
    assign w_wx = r_sgn ? {{DATA_WIDTH{weight_in[WEIGHT_WIDTH-1]}}, weight_in}
                        : {{DATA_WIDTH{1'b0}}, weight_in};
    assign w_prod = w_dx * w_wx;

    assign w_prod_x = r_sgn ? {{(SW-PW){w_prod[PW-1]}}, w_prod}
                            : {{(SW-PW){1'b0}}, w_prod};
    assign w_acc_x  = r_sgn ? {{(SW-A){r_acc[A-1]}}, r_acc}
                            : {{(SW-A){1'b0}}, r_acc};
    assign w_sum    = w_acc_x + w_prod_x;

    // Signed: out of range unless all bits from A-1 upward agree.
    // Unsigned: operands are non-negative, so only overflow is possible.
    assign w_ovf = r_sgn
        ? !((&w_sum[SW-1:A-1]) | ~(|w_sum[SW-1:A-1]))
        : (|w_sum[SW-1:A]);

    assign w_clamp = r_sgn
        ? (w_sum[SW-1] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}})
        : {A{1'b1}};

    assign w_next    = w_ovf ? w_clamp : w_sum[A-1:0];
    assign w_fire    = enable & data_valid_in & weight_valid_in;
    assign w_kcnt_nx = r_kcnt + 1'b1;

    assign w_ready = (r_state == S_PASS) & (~r_res_valid | result_ready_in);
    assign w_load  = result_valid_in & w_ready;
    assign w_drain = r_res_valid & result_ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_dv        <= 1'b0;
            r_wt        <= '0;
            r_wv        <= 1'b0;
            r_klen      <= '0;
            r_kcnt      <= '0;
            r_sgn       <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_fcnt      <= '0;
        end else begin
            if (enable) begin
                r_data <= data_in;
                r_dv   <= data_valid_in;
                r_wt   <= weight_in;
                r_wv   <= weight_valid_in;
            end else begin
                r_dv <= 1'b0;
                r_wv <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && enable) begin
                        r_klen <= k_len;
                        r_sgn  <= signed_mode;
                        r_acc  <= '0;
                        r_kcnt <= '0;
                        r_sat  <= 1'b0;
                        if (k_len == '0) begin
                            r_res       <= '0;
                            r_res_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_fire) begin
                        r_acc  <= w_next;
                        r_kcnt <= w_kcnt_nx;
                        if (w_ovf) begin
                            r_sat <= 1'b1;
                        end
                        if (w_kcnt_nx == r_klen) begin
                            r_res       <= w_next;
                            r_res_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_drain) begin
                        r_res_valid <= 1'b0;
                        r_fcnt      <= '0;
                        if (CHAIN_POS == 0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_PASS;
                        end
                    end
                end
                S_PASS: begin
                    if (w_drain && r_fcnt == CW'(CHAIN_POS - 1)) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        if (w_load) begin
                            r_res       <= result_in;
                            r_res_valid <= 1'b1;
                        end else if (w_drain) begin
                            r_res_valid <= 1'b0;
                        end
                        if (w_drain) begin
                            r_fcnt <= r_fcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data_out         = r_data;
    assign data_valid_out   = r_dv;
    assign weight_out       = r_wt;
    assign weight_valid_out = r_wv;
    assign result_out       = r_res;
    assign result_valid_out = r_res_valid;
    assign result_ready_out = w_ready;
    assign busy             = (r_state != S_IDLE);
    assign sat_flag         = r_sat;

endmodule

// File: tb/tb_systolic_pe_os.sv
// Testbench for systolic_pe_os: directed and random tiles checked
// against an arithmetic reference model, plus drain-chain ordering.
module tb_systolic_pe_os;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sm, dv, wv;
    logic [8:0]  kl;
    logic [15:0] din;
    logic [7:0]  win;

    logic        st0, rdy0, rvin0;
    logic [31:0] rin0;
    logic [15:0] dout0;
    logic [7:0]  wout0;
    logic        dvo0, wvo0, rro0, rvo0, busy0, sat0;
    logic [31:0] res0;

    logic        st1, rdy1, rvin1;
    logic [19:0] rin1;
    logic [15:0] dout1;
    logic [7:0]  wout1;
    logic        dvo1, wvo1, rro1, rvo1, busy1, sat1;
    logic [19:0] res1;

    int cmp = 0;
    int errs = 0;

    logic [15:0] dq[$];
    logic [7:0]  wq[$];
    int          gq[$];
    logic [63:0] exp_res;

    always #5 clk = ~clk;

    systolic_pe_os u0 (
        .clk(clk), .rst_n(rst_n), .enable(en), .start(st0),
        .k_len(kl), .signed_mode(sm),
        .data_in(din), .data_valid_in(dv),
        .data_out(dout0), .data_valid_out(dvo0),
        .weight_in(win), .weight_valid_in(wv),
        .weight_out(wout0), .weight_valid_out(wvo0),
        .result_in(rin0), .result_valid_in(rvin0),
        .result_ready_out(rro0),
        .result_out(res0), .result_valid_out(rvo0),
        .result_ready_in(rdy0),
        .busy(busy0), .sat_flag(sat0)
    );

    systolic_pe_os #(.ACCUM_WIDTH(20), .CHAIN_POS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(en), .start(st1),
        .k_len(kl), .signed_mode(sm),
        .data_in(din), .data_valid_in(dv),
        .data_out(dout1), .data_valid_out(dvo1),
        .weight_in(win), .weight_valid_in(wv),
        .weight_out(wout1), .weight_valid_out(wvo1),
        .result_in(rin1), .result_valid_in(rvin1),
        .result_ready_out(rro1),
        .result_out(res1), .result_valid_out(rvo1),
        .result_ready_in(rdy1),
        .busy(busy1), .sat_flag(sat1)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Saturating MAC over the queued pairs using plain integer arithmetic.
    function automatic void refm(input bit sgn, input int aw,
                                 output logic [63:0] r, output bit s);
        longint acc, d, w, mx, mn, one;
        one = 1;
        acc = 0;
        s = 1'b0;
        mx = sgn ? (one <<< (aw - 1)) - 1 : (one <<< aw) - 1;
        mn = sgn ? -(one <<< (aw - 1)) : 0;
        foreach (dq[i]) begin
            d = sgn ? longint'($signed(dq[i])) : longint'(dq[i]);
            w = sgn ? longint'($signed(wq[i])) : longint'(wq[i]);
            acc = acc + d * w;
            if (acc > mx) begin
                acc = mx;
                s = 1'b1;
            end else if (acc < mn) begin
                acc = mn;
                s = 1'b1;
            end
        end
        r = acc;
    endfunction

    task automatic run(input int u, input bit sgn);
        int k;
        logic [63:0] e;
        bit es;
        k = dq.size();
        refm(sgn, (u == 0) ? 32 : 20, e, es);
        exp_res = e;
        en = 1'b1;
        kl = 9'(k);
        sm = sgn;
        if (u == 0) st0 = 1'b1;
        else st1 = 1'b1;
        step;
        st0 = 1'b0;
        st1 = 1'b0;
        chk("start_busy", (u == 0) ? busy0 : busy1, 1);
        chk("start_sat", (u == 0) ? sat0 : sat1, 0);
        for (int i = 0; i < k; i++) begin
            dv = 1'b0;
            wv = 1'b0;
            repeat (gq[i]) step;
            din = dq[i];
            win = wq[i];
            dv = 1'b1;
            wv = 1'b1;
            step;
        end
        dv = 1'b0;
        wv = 1'b0;
        if (u == 0) begin
            chk("hold_valid", rvo0, 1);
            chk("result", res0, 64'(e[31:0]));
            chk("sat", sat0, 64'(es));
            chk("hold_ready", rro0, 0);
        end else begin
            chk("hold_valid", rvo1, 1);
            chk("result", res1, 64'(e[19:0]));
            chk("sat", sat1, 64'(es));
            chk("hold_ready", rro1, 0);
        end
        if (u == 0) begin
            step;
            chk("back_idle", busy0, 0);
        end
    endtask

    // Drain u1's own result then two upstream results, ready toggling.
    task automatic drain1(input logic [19:0] a, input logic [19:0] b);
        logic [19:0] got[$];
        logic [19:0] up[$];
        logic [19:0] want[3];
        int c;
        up = {a, b};
        want[0] = exp_res[19:0];
        want[1] = a;
        want[2] = b;
        c = 0;
        while (got.size() < 3 && c < 60) begin
            rvin1 = (up.size() > 0);
            rin1 = (up.size() > 0) ? up[0] : 20'd0;
            rdy1 = (c % 2 == 0);
            #1;
            if (rvo1 && rdy1) got.push_back(res1);
            if (rvin1 && rro1) void'(up.pop_front());
            c++;
            step;
        end
        rvin1 = 1'b0;
        rdy1 = 1'b0;
        chk("drain_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk("drain_order", got[i], want[i]);
        chk("drain_idle", busy1, 0);
    endtask

    task automatic setq1(input logic [15:0] d, input logic [7:0] w,
                         input int g);
        dq.push_back(d);
        wq.push_back(w);
        gq.push_back(g);
    endtask

    task automatic clrq;
        dq.delete();
        wq.delete();
        gq.delete();
    endtask

    task automatic randq(input int k);
        clrq();
        for (int i = 0; i < k; i++)
            setq1(16'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    endtask

    initial begin
        logic [63:0] e;
        bit es;
        rst_n = 1'b0;
        en = 1'b0; sm = 1'b0; dv = 1'b0; wv = 1'b0;
        kl = '0; din = '0; win = '0;
        st0 = 1'b0; rdy0 = 1'b1; rvin0 = 1'b0; rin0 = '0;
        st1 = 1'b0; rdy1 = 1'b0; rvin1 = 1'b0; rin1 = '0;
        repeat (2) step;
        chk("rst_res", res0, 0);
        chk("rst_rvo", rvo0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_dvo", dvo0, 0);
        chk("rst_sat", sat0, 0);
        chk("rst_rro1", rro1, 0);
        rst_n = 1'b1;
        step;

        // forwarding and stall
        en = 1'b1; din = 16'd5; win = 8'd3; dv = 1'b1; wv = 1'b1;
        step;
        chk("fwd_data", dout0, 5);
        chk("fwd_wt", wout0, 3);
        chk("fwd_dv", dvo0, 1);
        chk("fwd_wv", wvo0, 1);
        en = 1'b0;
        step;
        chk("stall_dv", dvo0, 0);
        chk("stall_wv", wvo0, 0);
        chk("stall_data", dout0, 5);
        en = 1'b1; dv = 1'b0; wv = 1'b0;
        step;

        // signed k=3 with a 2-cycle gap
        clrq();
        setq1(16'd1, 8'd4, 0);
        setq1(16'd2, 8'd5, 2);
        setq1(16'd3, 8'd6, 0);
        run(0, 1'b1);
        chk("k3_lit", exp_res, 32);

        // negative operands, both modes
        clrq();
        setq1(16'hFFFD, 8'hFE, 0);
        setq1(16'hFFFD, 8'hFE, 0);
        run(0, 1'b1);
        chk("neg_s_lit", exp_res, 12);
        run(0, 1'b0);
        chk("neg_u_lit", exp_res, 33290764);

        // k_len = 0 goes straight to HOLD with zero
        clrq();
        run(0, 1'b1);

        // stall inside ACCUM freezes the accumulator
        clrq();
        setq1(16'd10, 8'd3, 0);
        setq1(16'd20, 8'd4, 0);
        refm(1'b0, 32, e, es);
        kl = 9'd2; sm = 1'b0; st0 = 1'b1;
        step;
        st0 = 1'b0;
        din = 16'd10; win = 8'd3; dv = 1'b1; wv = 1'b1;
        step;
        en = 1'b0; din = 16'd100; win = 8'd100;
        repeat (3) step;
        chk("stall_busy", busy0, 1);
        chk("stall_rvo", rvo0, 0);
        en = 1'b1; din = 16'd20; win = 8'd4;
        step;
        dv = 1'b0; wv = 1'b0;
        chk("stall_res", res0, 64'(e[31:0]));
        chk("stall_lit", res0, 110);
        step;

        // reset in the middle of a tile
        kl = 9'd4; sm = 1'b1; st0 = 1'b1;
        step;
        st0 = 1'b0;
        din = 16'd7; win = 8'd7; dv = 1'b1; wv = 1'b1;
        repeat (2) step;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy0, 0);
        chk("mrst_res", res0, 0);
        chk("mrst_dvo", dvo0, 0);
        chk("mrst_dout", dout0, 0);
        chk("mrst_wvo", wvo0, 0);
        dv = 1'b0; wv = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        clrq();
        setq1(16'd2, 8'd3, 0);
        run(0, 1'b1);
        chk("mrst_new", exp_res, 6);

        // saturation on the narrow PE, then chain drain
        clrq();
        for (int i = 0; i < 4; i++) setq1(16'h7FFF, 8'h7F, 0);
        run(1, 1'b1);
        chk("sat_lit", exp_res, 524287);
        drain1(20'd7, 20'd9);
        clrq();
        setq1(16'd3, 8'd5, 0);
        run(1, 1'b0);
        drain1(20'd7, 20'd9);

        // random tiles
        for (int t = 0; t < 8; t++) begin
            randq(int'($urandom_range(1, 5)));
            run(0, 1'($urandom));
        end
        for (int t = 0; t < 4; t++) begin
            randq(int'($urandom_range(1, 4)));
            run(1, 1'($urandom));
            drain1(20'($urandom), 20'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
